io_mmio_ctrl: RTL
=================

// Module: io_mmio_ctrl
// PURPOSE
// Memory-mapped I/O controller for the 3-stage RISC-V core, upstream of the stage-3 control/writeback logic.
// Owns the cycle and retired-instruction counters, the UART TX holding register and the RX pop handshake.
// Supplies stage 3 with counter values, UART status bits and RX data; consumes stage-3 IO loads/stores (addr[31:30]==2'b10).
// PARAMETERS
// CNT_W      32  width of cyc_counter / instr_counter; wraps modulo 2^CNT_W
// PORTS
// clk                    in   1       core clock
// rst                    in   1       synchronous, active-high reset
// addr                   in   32      stage-3 data address (ALU result)
// wdata                  in   32      stage-3 store data; only [7:0] used
// io_valid               in   1       stage-3 slot holds a real (non-bubble, non-flushed) instruction
// is_load                in   1       stage-3 instruction is a load
// is_store               in   1       stage-3 instruction is a store
// instr_retire           in   1       one instruction retires this cycle
// uart_tx_data_in        out  8       byte to UART transmitter
// uart_tx_data_in_valid  out  1       TX byte valid
// uart_tx_data_in_ready  in   1       UART transmitter accepts byte
// uart_rx_data_out       in   8       byte from UART receiver
// uart_rx_data_out_valid in   1       RX byte available
// uart_rx_data_out_ready out  1       pop RX byte
// uart_rx_valid          out  1       status to stage 3 (== uart_rx_data_out_valid)
// uart_tx_ready          out  1       status to stage 3: holding register free
// uart_rx_out            out  8       RX byte to stage 3 (== uart_rx_data_out)
// cyc_counter            out  CNT_W   cycles since reset/clear
// instr_counter          out  CNT_W   retired instructions since reset/clear
// BEHAVIOUR
// - Address map (IO region, addr[31:30]==2'b10, low bits addr[4:2]): 0x80000000 UART ctrl {rx_valid,tx_ready},
//   0x80000004 RX data, 0x80000008 TX data, 0x80000010 cycle cnt, 0x80000014 instr cnt, 0x80000018 counter clear.
// - io_ld = io_valid & is_load & IO region; io_st = io_valid & is_store & IO region. Other regions ignored.
// - Reset (rst=1 at posedge): counters=0, TX FSM=IDLE, uart_tx_data_in=0, uart_tx_data_in_valid=0; reset mid-send drops byte.
// - cyc_counter: +1 every non-reset cycle. instr_counter: +1 on cycles with instr_retire=1.
// - io_st to 0x80000018: both counters read 0 the following cycle; clear beats same-cycle increment.
// - TX FSM, 2 states:
//   IDLE: uart_tx_ready=1, valid=0. io_st to 0x80000008 -> latch wdata[7:0], go SEND next cycle.
//   SEND: uart_tx_ready=0, valid=1, data held stable. uart_tx_data_in_ready=1 -> IDLE next cycle.
//   Stores to 0x80000008 while in SEND are dropped (software polls ctrl bit 0 first).
// - Min TX occupancy: 1 cycle SEND; store-to-next-store throughput 2 cycles when UART always ready.
// - RX: uart_rx_data_out_ready = io_ld & addr==0x80000004 & uart_rx_data_out_valid (combinational, 1-cycle pulse);
//   stage 3 samples uart_rx_out in that same cycle. Load with RX empty: no pop, returns stale byte.
// - Status/counter outputs are registered (counters, tx state) or direct pass-through (rx bits); zero added latency.
// - Loads to unmapped IO offsets and stores to read-only offsets: no side effect.
// TESTING
// - Reset 3 cycles, release: cyc_counter 0,1,2,... each cycle; instr_counter 0; uart_tx_ready=1; tx valid=0.
// - Store 0x41 to 0x80000008, UART ready held 0 for 4 cycles: valid=1, data=0x41 held, tx_ready=0; ready=1 -> IDLE next cycle.
// - Second store (0x42) during SEND: dropped; only 0x41 ever presented.
// - instr_retire high 10 cycles then store to 0x80000018 with instr_retire=1: instr_counter=0, cyc_counter=0 next cycle.
// - RX valid=1 byte 0x5A, load 0x80000004 with io_valid=1: ready pulses exactly 1 cycle, uart_rx_out=0x5A; io_valid=0 -> no pulse.
// - cyc_counter forced near wrap (CNT_W=4): 15 -> 0; rst asserted during SEND: valid=0 next cycle, FSM IDLE.

Source files
------------

// File: rtl/io_mmio_if.sv
// Stage-3 / UART bus bundle for the memory-mapped I/O controller.
// The master side is the environment (stage 3 plus the UART); the slave side is io_mmio_ctrl.
interface io_mmio_if #(
    parameter int unsigned CNT_W = 32
);
    // Stage-3 access
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             io_valid;
    logic             is_load;
    logic             is_store;
    logic             instr_retire;

    // UART transmitter side
    logic [7:0]       uart_tx_data_in;
    logic             uart_tx_data_in_valid;
    logic             uart_tx_data_in_ready;

    // UART receiver side
    logic [7:0]       uart_rx_data_out;
    logic             uart_rx_data_out_valid;
    logic             uart_rx_data_out_ready;

    // Status and data returned to stage 3
    logic             uart_rx_valid;
    logic             uart_tx_ready;
    logic [7:0]       uart_rx_out;
    logic [CNT_W-1:0] cyc_counter;
    logic [CNT_W-1:0] instr_counter;

    modport master (
        output addr, wdata, io_valid, is_load, is_store, instr_retire,
        output uart_tx_data_in_ready, uart_rx_data_out, uart_rx_data_out_valid,
        input  uart_tx_data_in, uart_tx_data_in_valid, uart_rx_data_out_ready,
        input  uart_rx_valid, uart_tx_ready, uart_rx_out, cyc_counter, instr_counter
    );

    modport slave (
        input  addr, wdata, io_valid, is_load, is_store, instr_retire,
        input  uart_tx_data_in_ready, uart_rx_data_out, uart_rx_data_out_valid,
        output uart_tx_data_in, uart_tx_data_in_valid, uart_rx_data_out_ready,
        output uart_rx_valid, uart_tx_ready, uart_rx_out, cyc_counter, instr_counter
    );
endinterface

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped I/O controller: cycle/instret counters, UART TX holding register, RX pop.
// IO region is addr[31:30] == 2'b10; registers are selected by addr[4:2].
module io_mmio_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input logic       clk,
    input logic       rst,
    io_mmio_if.slave  bus
);
    localparam logic [1:0] IO_REGION  = 2'b10;
    localparam logic [2:0] OFF_RX     = 3'd1;   // 0x80000004
    localparam logic [2:0] OFF_TX     = 3'd2;   // 0x80000008
    localparam logic [2:0] OFF_CLR    = 3'd6;   // 0x80000018

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    tx_state_t        tx_state;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_free;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] instr_cnt;

    logic             in_io;
    logic             io_ld;
    logic             io_st;
    logic             st_tx;
    logic             st_clr;
    logic             ld_rx;
    logic             unused_bits;

    // Decode of the stage-3 access; anything outside the IO region is ignored
    assign in_io  = (bus.addr[31:30] == IO_REGION);
    assign io_ld  = bus.io_valid & bus.is_load  & in_io;
    assign io_st  = bus.io_valid & bus.is_store & in_io;
    assign st_tx  = io_st & (bus.addr[4:2] == OFF_TX);
    assign st_clr = io_st & (bus.addr[4:2] == OFF_CLR);
    assign ld_rx  = io_ld & (bus.addr[4:2] == OFF_RX);

    // Address bits and store-data bits that no register looks at
    assign unused_bits = ^{bus.addr[29:5], bus.addr[1:0], bus.wdata[31:8]};

    // Free-running counters; a clear store wins over the same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else if (st_clr) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (bus.instr_retire) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    // TX holding register FSM; stores arriving while a byte is pending are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            tx_free  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (st_tx) begin
                        tx_data  <= bus.wdata[7:0];
                        tx_valid <= 1'b1;
                        tx_free  <= 1'b0;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (bus.uart_tx_data_in_ready) begin
                        tx_valid <= 1'b0;
                        tx_free  <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    tx_free  <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // Outputs: TX side and counters from flops, RX side passed straight through
    assign bus.uart_tx_data_in        = tx_data;
    assign bus.uart_tx_data_in_valid  = tx_valid;
    assign bus.uart_tx_ready          = tx_free;
    assign bus.cyc_counter            = cyc_cnt;
    assign bus.instr_counter          = instr_cnt;
    assign bus.uart_rx_data_out_ready = ld_rx & bus.uart_rx_data_out_valid;
    assign bus.uart_rx_valid          = bus.uart_rx_data_out_valid;
    assign bus.uart_rx_out            = bus.uart_rx_data_out;
endmodule
